// File: rtl/move_sequencer.sv
// Move sequencer: accepts a move of N squares, ramps frwrd up toward MAX_SPD,
// counts line crossings to the target, ramps frwrd back to zero and pulses move_done.
module move_sequencer #(
  parameter logic [9:0] INC     = 10'h010,
  parameter logic [9:0] DEC     = 10'h020,
  parameter logic [9:0] MAX_SPD = 10'h300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_vld,
  input  logic [3:0] cmd_sqrs,
  output logic       cmd_rdy,
  input  logic       heading_rdy,
  input  logic       cntrIR,
  input  logic       abort,
  output logic       moving,
  output logic [9:0] frwrd,
  output logic       move_done
);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DN, DONE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic        moving_q, moving_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        move_done_q, move_done_d;
  logic [4:0]  count_q, count_d;
  logic [4:0]  target_q, target_d;
  logic        cntr_ir_q;
  logic        cntr_rise;
  logic [10:0] up_sum;

  assign cntr_rise = cntrIR & ~cntr_ir_q;
  // Eleven-bit sum so the saturation compare cannot be fooled by a wrap.
  assign up_sum    = {1'b0, frwrd_q} + {1'b0, INC};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      frwrd_q     <= '0;
      moving_q    <= 1'b0;
      cmd_rdy_q   <= 1'b1;
      move_done_q <= 1'b0;
      count_q     <= '0;
      target_q    <= '0;
      cntr_ir_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frwrd_q     <= frwrd_d;
      moving_q    <= moving_d;
      cmd_rdy_q   <= cmd_rdy_d;
      move_done_q <= move_done_d;
      count_q     <= count_d;
      target_q    <= target_d;
      cntr_ir_q   <= cntrIR;
    end
  end

  always_comb begin
    state_d  = state_q;
    frwrd_d  = frwrd_q;
    count_d  = count_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (cmd_vld && cmd_rdy_q) begin
          target_d = {cmd_sqrs, 1'b0};
          count_d  = '0;
          state_d  = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (heading_rdy) begin
          frwrd_d = (up_sum > {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[9:0];
        end
        if (cntr_rise && (count_q != 5'd31)) begin
          count_d = count_q + 5'd1;
        end
        if ((count_q == target_q) || abort) begin
          state_d = RAMP_DN;
        end
      end
      RAMP_DN: begin
        if (heading_rdy) begin
          frwrd_d = (frwrd_q <= DEC) ? 10'h000 : (frwrd_q - DEC);
        end
        // Completion looks at the registered speed, so a ramp-down from 0 ends at once.
        if (frwrd_q == 10'h000) begin
          state_d = DONE;
        end
      end
      DONE: begin
        frwrd_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    moving_d    = 1'b0;
    cmd_rdy_d   = 1'b0;
    move_done_d = 1'b0;
    case (state_d)
      IDLE:    cmd_rdy_d   = 1'b1;
      RAMP_UP: moving_d    = 1'b1;
      RAMP_DN: moving_d    = 1'b1;
      DONE:    move_done_d = 1'b1;
      default: cmd_rdy_d   = 1'b0;
    endcase
  end

  assign frwrd     = frwrd_q;
  assign moving    = moving_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign move_done = move_done_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: a per-cycle vector table plus
// hand-written ramp sequences, all checked through an expected-value queue.
module tb_move_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_vld;
  logic [3:0] cmd_sqrs;
  logic       cmd_rdy;
  logic       heading_rdy;
  logic       cntrIR;
  logic       abort;
  logic       moving;
  logic [9:0] frwrd;
  logic       move_done;

  move_sequencer dut (
    .clk(clk),
    .rst(rst),
    .cmd_vld(cmd_vld),
    .cmd_sqrs(cmd_sqrs),
    .cmd_rdy(cmd_rdy),
    .heading_rdy(heading_rdy),
    .cntrIR(cntrIR),
    .abort(abort),
    .moving(moving),
    .frwrd(frwrd),
    .move_done(move_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] frwrd;
    logic       moving;
    logic       cmd_rdy;
    logic       move_done;
  } exp_t;

  typedef struct {
    logic       vld;
    logic [3:0] sqrs;
    logic       hdg;
    logic       cir;
    logic       abt;
    logic [9:0] frwrd;
    logic       moving;
    logic       rdy;
    logic       done;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[18];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectOut(input logic [9:0] f, input logic m, input logic r, input logic d);
    exp_t e;
    e.frwrd     = f;
    e.moving    = m;
    e.cmd_rdy   = r;
    e.move_done = d;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: no expected entry queued", name);
    end else begin
      e = sb_q.pop_front();
      if (frwrd !== e.frwrd || moving !== e.moving || cmd_rdy !== e.cmd_rdy ||
          move_done !== e.move_done) begin
        errors++;
        $display("[TB] FAIL %s: got frwrd=%h moving=%b cmd_rdy=%b move_done=%b, want frwrd=%h moving=%b cmd_rdy=%b move_done=%b",
                 name, frwrd, moving, cmd_rdy, move_done,
                 e.frwrd, e.moving, e.cmd_rdy, e.move_done);
      end
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [3:0] sqrs, input logic hdg,
                               input logic cir, input logic abt);
    cmd_vld     = vld;
    cmd_sqrs    = sqrs;
    heading_rdy = hdg;
    cntrIR      = cir;
    abort       = abt;
    tick();
  endtask

  task automatic step(input string name, input logic vld, input logic [3:0] sqrs,
                      input logic hdg, input logic cir, input logic abt,
                      input logic [9:0] f, input logic m, input logic r, input logic d);
    expectOut(f, m, r, d);
    applyStimulus(vld, sqrs, hdg, cir, abt);
    checkOutput(name);
  endtask

  task automatic rampUp(input string name, input int pulses, output logic [9:0] last);
    logic [10:0] v;
    v = 11'h000;
    for (int k = 0; k < pulses; k++) begin
      v = v + 11'h010;
      if (v > 11'h300) v = 11'h300;
      step(name, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, v[9:0], 1'b1, 1'b0, 1'b0);
      step({name, "_hold"}, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, v[9:0], 1'b1, 1'b0, 1'b0);
    end
    last = v[9:0];
  endtask

  task automatic rampDown(input string name, input logic [9:0] start, input int pulses);
    logic [9:0] v;
    v = start;
    for (int k = 0; k < pulses; k++) begin
      v = (v > 10'h020) ? v - 10'h020 : 10'h000;
      step(name, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, v, 1'b1, 1'b0, 1'b0);
      if (v != 10'h000) begin
        step({name, "_hold"}, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, v, 1'b1, 1'b0, 1'b0);
      end
    end
    step({name, "_done"}, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    step({name, "_idle"}, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic crossings(input string name, input int edges, input logic [9:0] f);
    for (int k = 0; k < edges; k++) begin
      step(name, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, f, 1'b1, 1'b0, 1'b0);
      step(name, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, f, 1'b1, 1'b0, 1'b0);
    end
  endtask

  logic [9:0] top;

  initial begin
    // Move of 1 square with cmd_vld held high, then a zero-square move.
    vecs[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 10'h010, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 10'h020, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 10'h030, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 10'h040, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 10'h040, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 10'h040, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 10'h050, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 10'h050, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 10'h030, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 10'h010, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    cmd_vld = 1'b0;
    cmd_sqrs = 4'd0;
    heading_rdy = 1'b0;
    cntrIR = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    expectOut(10'h000, 1'b0, 1'b1, 1'b0);
    checkOutput("reset_state");
    rst = 1'b0;
    step("idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a ramp-up.
    step("rst_accept", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0);
    rampUp("rst_ramp", 8, top);
    rst = 1'b1;
    #2;
    expectOut(10'h000, 1'b0, 1'b1, 1'b0);
    checkOutput("async_reset");
    tick();
    tick();
    rst = 1'b0;
    step("after_reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);

    // One-square move.
    step("one_accept", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0);
    rampUp("one_up", 10, top);
    crossings("one_cross", 2, 10'h0A0);
    rampDown("one_dn", 10'h0A0, 5);

    // Saturation at MAX_SPD over a fifteen-square move.
    step("sat_accept", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0);
    rampUp("sat_up", 60, top);
    crossings("sat_cross", 29, 10'h300);
    step("sat_not_yet", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'h300, 1'b1, 1'b0, 1'b0);
    crossings("sat_last", 1, 10'h300);
    rampDown("sat_dn", 10'h300, 24);

    // Abort with a speed that is not a multiple of DEC; crossings and abort ignored in ramp-down.
    step("abt_accept", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0);
    rampUp("abt_up", 11, top);
    step("abt_hit", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 10'h0B0, 1'b1, 1'b0, 1'b0);
    step("abt_cir_hi", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 10'h0B0, 1'b1, 1'b0, 1'b0);
    step("abt_cir_lo", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h0B0, 1'b1, 1'b0, 1'b0);
    rampDown("abt_dn", 10'h0B0, 6);

    for (int i = 0; i < 18; i++) begin
      step($sformatf("vec%0d", i), vecs[i].vld, vecs[i].sqrs, vecs[i].hdg, vecs[i].cir,
           vecs[i].abt, vecs[i].frwrd, vecs[i].moving, vecs[i].rdy, vecs[i].done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
